// File: rtl/shot_clock_input_ctrl.sv
// shot_clock_input_ctrl: syncs and debounces board keys/switch into pause, clock_rst pulse and mode_switch.
// Optional reset-key hold feature enabled by defining SHOT_CLOCK_HOLD_EN.
module shot_clock_input_ctrl #(
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int RST_PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES      = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_pause_n,
  input  logic key_reset_n,
  input  logic sw_mode,
  output logic pause,
  output logic clock_rst,
  output logic mode_switch,
  output logic hold_active
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
  // bit 0 pause key, bit 1 reset key, bit 2 mode switch; keys idle released (high)
  localparam logic [2:0] INIT = 3'b011;
  typedef enum logic {IDLE, PULSE} state_t;
  state_t state;
  logic [PW-1:0] pcnt;
  logic [2:0] raw, s1, s2, deb, deb_d;
  logic [CW-1:0] cnt [3];
  logic pause_press, rst_press, mode_chg, trig, hold_fire;
  assign raw = {sw_mode, key_reset_n, key_pause_n};
  assign pause_press = deb_d[0] & ~deb[0];
  assign rst_press = deb_d[1] & ~deb[1];
  assign mode_chg = deb_d[2] ^ deb[2];
  assign trig = rst_press | mode_chg;
  assign mode_switch = deb_d[2];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= INIT;
      s2 <= INIT;
      deb <= INIT;
      deb_d <= INIT;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++)
        if (s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  // a trigger during a pulse reloads the counter, so pulses only ever stretch
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pcnt <= '0;
      clock_rst <= 1'b0;
    end else if (trig) begin
      state <= PULSE;
      pcnt <= PW'(RST_PULSE_CYCLES - 1);
      clock_rst <= 1'b1;
    end else if (state == PULSE && pcnt == '0) begin
      state <= IDLE;
      clock_rst <= 1'b0;
    end else if (state == PULSE) pcnt <= pcnt - 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) pause <= 1'b0;
    else if (rst_press) pause <= 1'b0;
    else if (hold_fire) pause <= 1'b1;
    else if (pause_press) pause <= ~(pause | hold_active);
`ifdef SHOT_CLOCK_HOLD_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [HW-1:0] hcnt;
  assign hold_fire = ~deb[1] && hcnt == HW'(HOLD_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hcnt <= '0;
      hold_active <= 1'b0;
    end else begin
      hcnt <= deb[1] ? '0 : (hcnt == HW'(HOLD_CYCLES)) ? hcnt : hcnt + 1'b1;
      hold_active <= hold_fire | (hold_active & ~pause_press);
    end
`else
  assign hold_fire = 1'b0;
  assign hold_active = 1'b0;
`endif
endmodule

// File: tb/tb_shot_clock_input_ctrl.sv
// tb_shot_clock_input_ctrl: directed stimulus against a window-based behavioural model of the input conditioner.
module tb_shot_clock_input_ctrl;
  localparam int D = 4, R = 2, H = 20;
`ifdef SHOT_CLOCK_HOLD_EN
  localparam bit HE = 1'b1;
`else
  localparam bit HE = 1'b0;
`endif
  localparam logic [2:0] INIT = 3'b011;
  logic clk = 1'b0, rst = 1'b1, key_pause_n = 1'b1, key_reset_n = 1'b1, sw_mode = 1'b0;
  logic pause, clock_rst, mode_switch, hold_active;
  int checks = 0, failures = 0, n, w;
  shot_clock_input_ctrl #(.DEBOUNCE_CYCLES(D), .RST_PULSE_CYCLES(R), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .key_pause_n(key_pause_n), .key_reset_n(key_reset_n), .sw_mode(sw_mode),
    .pause(pause), .clock_rst(clock_rst), .mode_switch(mode_switch), .hold_active(hold_active));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  // model: a level is accepted once D consecutive synced samples disagree with it;
  // the resulting events act one edge later; a pulse lasts R edges past the latest trigger
  logic [63:0] h [3];
  logic [2:0] md, mdd, raw_m;
  logic pm, mm, hm, cm, pp, rp, mc, fire, diff;
  int low_n, en, last;
  assign raw_m = {sw_mode, key_reset_n, key_pause_n};
  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 3; i++) h[i] = {64{INIT[i]}};
      md = INIT; mdd = INIT;
      pm = 0; mm = 0; hm = 0; cm = 0;
      low_n = 0; en = 0; last = -100;
    end else begin
      en++;
      pp = mdd[0] & ~md[0];
      rp = mdd[1] & ~md[1];
      mc = mdd[2] ^ md[2];
      if (rp || mc) last = en;
      mm = md[2];
      fire = 0;
      if (HE) begin
        low_n = md[1] ? 0 : low_n + 1;
        fire = (low_n == H);
      end
      if (rp) pm = 0;
      else if (fire) pm = 1;
      else if (pp) pm = hm ? 1'b0 : !pm;
      if (fire) hm = 1;
      else if (pp) hm = 0;
      mdd = md;
      for (int i = 0; i < 3; i++) begin
        diff = 1;
        for (int k = 1; k <= D; k++) if (h[i][k] == md[i]) diff = 0;
        if (diff) md[i] = ~md[i];
        h[i] = {h[i][62:0], raw_m[i]};
      end
      cm = (en - last) < R;
    end
  always @(negedge clk)
    if (!rst) begin
      chk("model_pause", int'(pause), int'(pm));
      chk("model_clock_rst", int'(clock_rst), int'(cm));
      chk("model_mode_switch", int'(mode_switch), int'(mm));
      chk("model_hold_active", int'(hold_active), int'(hm));
    end
  function automatic logic get(input int s);
    return s == 0 ? pause : s == 1 ? clock_rst : s == 2 ? mode_switch : hold_active;
  endfunction
  task automatic wait_for(input int sel, input logic v, output int cnt);
    cnt = 0;
    while (get(sel) !== v && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask
  task automatic width(output int cnt);
    cnt = 0;
    while (clock_rst === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
  endtask
  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask
  initial begin
    idle(3);
    chk("rst_pause", int'(pause), 0);
    chk("rst_clock_rst", int'(clock_rst), 0);
    chk("rst_mode_switch", int'(mode_switch), 0);
    chk("rst_hold_active", int'(hold_active), 0);
    rst = 0;
    idle(50);
    chk("idle_pause", int'(pause), 0);
    chk("idle_clock_rst", int'(clock_rst), 0);
    key_pause_n = 0;
    wait_for(0, 1, n); chk("pause_lat1", n, 7);
    idle(13); key_pause_n = 1; idle(20);
    key_pause_n = 0;
    wait_for(0, 0, n); chk("pause_lat2", n, 7);
    idle(13); key_pause_n = 1; idle(20);
    chk("pause_release", int'(pause), 0);
    key_pause_n = 0; idle(2); key_pause_n = 1; idle(2);
    key_pause_n = 0; idle(2); key_pause_n = 1; idle(2);
    key_pause_n = 0;
    wait_for(0, 1, n); chk("bounce_lat", n, 7);
    idle(13); key_pause_n = 1; idle(20);
    key_reset_n = 0;
    wait_for(1, 1, n); chk("rst_key_lat", n, 7);
    chk("rst_key_pause", int'(pause), 0);
    width(w); chk("rst_key_width", w, 2);
    key_reset_n = 1; idle(20);
    sw_mode = 1;
    wait_for(2, 1, n); chk("mode_lat", n, 7);
    chk("mode_crst_same", int'(clock_rst), 1);
    width(w); chk("mode_width", w, 2);
    idle(20);
    sw_mode = 0; key_reset_n = 0;
    wait_for(1, 1, n); chk("combo_lat", n, 7);
    chk("combo_mode", int'(mode_switch), 0);
    width(w); chk("combo_width", w, 2);
    key_reset_n = 1; idle(20);
    sw_mode = 1; idle(1); key_reset_n = 0;
    wait_for(1, 1, n); chk("ext_lat", n, 6);
    width(w); chk("ext_width", w, 3);
    key_reset_n = 1; idle(20);
    sw_mode = 0; idle(20);
    key_reset_n = 0;
    if (HE) begin
      wait_for(3, 1, n); chk("hold_lat", n, 26);
      chk("hold_pause", int'(pause), 1);
      idle(14);
    end else begin
      idle(40);
      chk("hold_off", int'(hold_active), 0);
    end
    key_reset_n = 1; idle(20);
    key_pause_n = 0;
    wait_for(0, HE ? 1'b0 : 1'b1, n); chk("post_hold_lat", n, 7);
    chk("post_hold_active", int'(hold_active), 0);
    idle(13); key_pause_n = 1; idle(20);
    key_pause_n = 0; idle(3);
    rst = 1; key_pause_n = 1; idle(2);
    rst = 0; idle(20);
    chk("mid_deb_pause", int'(pause), 0);
    key_reset_n = 0;
    wait_for(1, 1, n); chk("mid_pulse_lat", n, 7);
    key_reset_n = 1; rst = 1;
    #1 chk("mid_pulse_async", int'(clock_rst), 0);
    idle(2); rst = 0; idle(20);
    chk("mid_pulse_after", int'(clock_rst), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
